i2c_arbiter: RTL and testbench
==============================

# i2c_arbiter

Shares one `i2c_master` instance between `NUM_REQUESTERS` register-access clients, such as a sensor bring-up sequencer and a runtime exposure/gain updater on the same camera bus. Grants ownership per I2C transaction using round-robin order. The owner's command signals are muxed onto the master, and the master's status is routed back only to the owner. The block sits directly between the clients and `i2c_master`.

## Interface
- `NUM_REQUESTERS`, 2: number of clients; legal values 2..4.
- `TIMEOUT_CYCLES`, 65535: idle-owner watchdog limit; used only with the timeout feature.
- `clk_in` input 1: clock, same clock domain as `i2c_master`.
- `reset` input 1: asynchronous, active-high reset.
- `req` input N: client i requests or holds ownership.
- `grant` output N: one-hot or zero; bit i means client i owns the master.
- `req_address` input 8N: per-client address byte, slice i = [8i+7:8i].
- `req_data_tx` input 8N: per-client TX byte.
- `req_transfer_start`, `req_transfer_continues` input N: per-client master controls.
- `req_transfer_ready`, `req_interrupt`, `req_transaction_complete` output N: master status, gated to the owner.
- `address`, `data_tx` output 8: to `i2c_master`.
- `transfer_start`, `transfer_continues` output 1: to `i2c_master`.
- `transfer_ready`, `interrupt`, `transaction_complete`, `nack`, `address_err` input 1: from `i2c_master`.
- `data_rx` input 8: from `i2c_master`.
- `rx_data`, `rx_nack`, `rx_address_err` output 8/1/1: broadcast to all clients. Meaningful only when qualified by the client's own `req_interrupt`.
- `timeout_err` output N: one-cycle pulse to the client whose grant was revoked.

## Operation
- States: IDLE, GRANTED, RELEASE.
- **IDLE**
  - `grant` = 0.
  - Master outputs are driven to 0.
  - If `transfer_ready` = 1 and any `req` bit is set: pick the first set bit searching upward from `last+1` (wrapping), register it into `grant` and `last`, and go to GRANTED.
- **GRANTED**
  - Master command outputs are a combinational mux of the owner's slice selected by `grant`.
  - `req_*` status outputs equal the master signals ANDed with `grant`.
- **Leaving GRANTED** (go to RELEASE) on any of:
  - (a) `transaction_complete` = 1;
  - (b) `interrupt` & `address_err`;
  - (c) owner's `req` = 0 while `transfer_ready` = 1 and the owner's `req_transfer_continues` = 0, meaning no bus transaction is open.
- A `req` drop in the middle of a transaction is ignored until one of the release conditions holds.
- **RELEASE**
  - `grant` = 0.
  - `transfer_start` is forced to 0.
  - Lasts exactly 1 cycle, then IDLE.
- **Fairness:** `last` resets to N-1, so client 0 wins first. `last` wraps modulo N. A client that keeps `req` high can win again only after every other pending client has been served.
- **NACK:** write NACKs are not handled here. `nack` is forwarded and the owner must end its transaction.
- **Reset values:** state = IDLE, `grant` = 0, `last` = N-1, `transfer_start` = 0, `transfer_continues` = 0, `address` = 0, `data_tx` = 0, `timeout_err` = 0, and all `req_*` status outputs = 0.
- **Reset during GRANTED:** ownership drops immediately. The bus state of `i2c_master` is its own concern.

## Timing
- **Grant latency:**
  - Cycle 0 condition: `req[i]` high in IDLE with `transfer_ready` high.
  - Result: `grant[i]` is high at cycle 1.
  - `req_transfer_ready[i]` is visible in the same cycle as `grant`.
  - The owner's `transfer_start` reaches the master combinationally, with no added cycle.
- **Release:**
  - Cycle t: release condition true.
  - Cycle t+1: `grant` = 0 (RELEASE).
  - Cycle t+2: IDLE.
  - Cycle t+3: next grant at the earliest.
  - Minimum gap between grants: 2 cycles.
- **Simultaneous events:**
  - `transaction_complete` with a timeout in the same cycle: treat as completion; no `timeout_err`.
  - Several clients raising `req` in the same cycle: resolved purely by round-robin order.
- **Outputs:** all master outputs are glitch-free across ownership changes because `grant` is registered.

## Configuration
- Macro: `I2C_ARBITER_TIMEOUT_EN`.
- **Defined:**
  - A 16-bit counter runs in GRANTED.
  - It increments on each cycle where `transfer_ready` = 1 and the owner's `req_transfer_start` = 0.
  - It clears on any other cycle and on grant.
  - When it reaches `TIMEOUT_CYCLES`: pulse `timeout_err[owner]` for 1 cycle (in the same cycle `grant` falls) and go to RELEASE.
- **Undefined:** no counter is built and `timeout_err` is tied to 0. A stuck owner then holds the bus indefinitely.

## Test plan
- **Reset and first grant:** N=2, reset, then `req` = 2'b11 with `transfer_ready` = 1 → `grant` = 2'b01 one cycle later; all master outputs 0 until then.
- **Round-robin:** both requesters hold `req`; client 0 finishes with a `transaction_complete` pulse at cycle t → `grant` = 0 at t+1, `grant` = 2'b10 at t+3, then back to 2'b01 after client 1 completes.
- **Mid-transaction drop:** owner drops `req` while its `transfer_continues` = 1 → `grant` holds; release happens on the following `transaction_complete`.
- **Status gating:** `interrupt` pulses while client 1 owns → `req_interrupt` = 2'b10 and `rx_data` equals `data_rx`.
- **Address error:** `interrupt` = 1 with `address_err` = 1 → `grant` = 0 on the next cycle.
- **Timeout (macro defined, `TIMEOUT_CYCLES` = 8):** owner idles with `transfer_ready` = 1 → `timeout_err` pulses after 8 idle cycles and `grant` clears. The same stimulus with the macro undefined → `grant` held and `timeout_err` = 0.

Source files
------------

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter that shares one i2c_master between NUM_REQUESTERS clients, one transaction per grant.
// Optional idle-owner watchdog enabled by defining I2C_ARBITER_TIMEOUT_EN.
module i2c_arbiter #(
    parameter int NUM_REQUESTERS = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic [NUM_REQUESTERS-1:0]     req,
    output logic [NUM_REQUESTERS-1:0]     grant,
    input  logic [8*NUM_REQUESTERS-1:0]   req_address,
    input  logic [8*NUM_REQUESTERS-1:0]   req_data_tx,
    input  logic [NUM_REQUESTERS-1:0]     req_transfer_start,
    input  logic [NUM_REQUESTERS-1:0]     req_transfer_continues,
    output logic [NUM_REQUESTERS-1:0]     req_transfer_ready,
    output logic [NUM_REQUESTERS-1:0]     req_interrupt,
    output logic [NUM_REQUESTERS-1:0]     req_transaction_complete,
    output logic [7:0]                    address,
    output logic [7:0]                    data_tx,
    output logic                          transfer_start,
    output logic                          transfer_continues,
    input  logic                          transfer_ready,
    input  logic                          interrupt,
    input  logic                          transaction_complete,
    input  logic                          nack,
    input  logic                          address_err,
    input  logic [7:0]                    data_rx,
    output logic [7:0]                    rx_data,
    output logic                          rx_nack,
    output logic                          rx_address_err,
    output logic [NUM_REQUESTERS-1:0]     timeout_err
);

    typedef enum logic [1:0] {IDLE, GRANTED, RELEASE} state_t;

    state_t     state;
    logic [1:0] last;
    logic       pick_valid;
    logic [1:0] pick_idx;
    logic       owner_req;
    logic       owner_cont;
    logic       release_cond;
    logic       timeout_hit;

    // Search upward from the client after the last winner, wrapping modulo N.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = last;
        for (int k = 1; k <= NUM_REQUESTERS; k++) begin
            for (int i = 0; i < NUM_REQUESTERS; i++) begin
                if (!pick_valid && req[i] && (i == (int'(last) + k) % NUM_REQUESTERS)) begin
                    pick_valid = 1'b1;
                    pick_idx   = 2'(i);
                end
            end
        end
    end

    // Grant is one-hot or zero, so the owner's slice passes through and everything is 0 otherwise.
    always_comb begin
        address            = '0;
        data_tx            = '0;
        transfer_start     = 1'b0;
        transfer_continues = 1'b0;
        owner_req          = 1'b0;
        owner_cont         = 1'b0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (grant[i]) begin
                address            = req_address[8*i +: 8];
                data_tx            = req_data_tx[8*i +: 8];
                transfer_start     = req_transfer_start[i];
                transfer_continues = req_transfer_continues[i];
                owner_req          = req[i];
                owner_cont         = req_transfer_continues[i];
            end
        end
    end

    assign req_transfer_ready       = {NUM_REQUESTERS{transfer_ready}} & grant;
    assign req_interrupt            = {NUM_REQUESTERS{interrupt}} & grant;
    assign req_transaction_complete = {NUM_REQUESTERS{transaction_complete}} & grant;
    assign rx_data                  = data_rx;
    assign rx_nack                  = nack;
    assign rx_address_err           = address_err;

    // A dropped req only releases once no bus transaction is open.
    assign release_cond = transaction_complete
                        | (interrupt & address_err)
                        | (~owner_req & transfer_ready & ~owner_cont);

`ifdef I2C_ARBITER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] idle_cnt;
    logic        idle_cond;

    assign idle_cond   = transfer_ready & ~|(req_transfer_start & grant);
    assign timeout_hit = (state == GRANTED) && idle_cond && (idle_cnt == TIMEOUT_LAST);

    // A normal release in the same cycle wins over the watchdog and suppresses the error pulse.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            idle_cnt    <= '0;
            timeout_err <= '0;
        end else begin
            timeout_err <= '0;
            if (state == GRANTED && !release_cond && idle_cond) begin
                if (timeout_hit) begin
                    timeout_err <= grant;
                    idle_cnt    <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 16'd1;
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end
`else
    // Without the watchdog the limit has no effect; a stuck owner keeps the bus.
    assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
    assign timeout_err = '0;
`endif

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            last  <= 2'(NUM_REQUESTERS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (transfer_ready && pick_valid) begin
                        grant <= {{(NUM_REQUESTERS-1){1'b0}}, 1'b1} << pick_idx;
                        last  <= pick_idx;
                        state <= GRANTED;
                    end
                end
                GRANTED: begin
                    if (release_cond || timeout_hit) begin
                        grant <= '0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter: directed scenarios plus randomized traffic against a cycle model.
module tb_i2c_arbiter;

    localparam int N     = 2;
    localparam int LIMIT = 8;
`ifdef I2C_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk_in;
    logic             reset;
    logic [N-1:0]     req;
    logic [N-1:0]     grant;
    logic [8*N-1:0]   req_address;
    logic [8*N-1:0]   req_data_tx;
    logic [N-1:0]     req_transfer_start;
    logic [N-1:0]     req_transfer_continues;
    logic [N-1:0]     req_transfer_ready;
    logic [N-1:0]     req_interrupt;
    logic [N-1:0]     req_transaction_complete;
    logic [7:0]       address;
    logic [7:0]       data_tx;
    logic             transfer_start;
    logic             transfer_continues;
    logic             transfer_ready;
    logic             interrupt;
    logic             transaction_complete;
    logic             nack;
    logic             address_err;
    logic [7:0]       data_rx;
    logic [7:0]       rx_data;
    logic             rx_nack;
    logic             rx_address_err;
    logic [N-1:0]     timeout_err;

    i2c_arbiter #(.NUM_REQUESTERS(N), .TIMEOUT_CYCLES(LIMIT)) dut (
        .clk_in                   (clk_in),
        .reset                    (reset),
        .req                      (req),
        .grant                    (grant),
        .req_address              (req_address),
        .req_data_tx              (req_data_tx),
        .req_transfer_start       (req_transfer_start),
        .req_transfer_continues   (req_transfer_continues),
        .req_transfer_ready       (req_transfer_ready),
        .req_interrupt            (req_interrupt),
        .req_transaction_complete (req_transaction_complete),
        .address                  (address),
        .data_tx                  (data_tx),
        .transfer_start           (transfer_start),
        .transfer_continues       (transfer_continues),
        .transfer_ready           (transfer_ready),
        .interrupt                (interrupt),
        .transaction_complete     (transaction_complete),
        .nack                     (nack),
        .address_err              (address_err),
        .data_rx                  (data_rx),
        .rx_data                  (rx_data),
        .rx_nack                  (rx_nack),
        .rx_address_err           (rx_address_err),
        .timeout_err              (timeout_err)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    // Reference model: current owner (-1 when none), cycles left before arbitration may happen,
    // last winner, consecutive idle cycles of the owner and the pending timeout pulse.
    int          m_owner;
    int          m_gap;
    int          m_last;
    int          m_cnt;
    logic [31:0] m_terr;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit chance(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    function automatic logic [N-1:0] randBits(input int pct);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = chance(pct);
        return v;
    endfunction

    task automatic applyStimulus(input logic [N-1:0] r, input logic tr, input logic tc,
                                 input logic intr, input logic aerr,
                                 input logic [N-1:0] st, input logic [N-1:0] co);
        req                    = r;
        transfer_ready         = tr;
        transaction_complete   = tc;
        interrupt              = intr;
        address_err            = aerr;
        req_transfer_start     = st;
        req_transfer_continues = co;
        req_address            = (8*N)'($urandom);
        req_data_tx            = (8*N)'($urandom);
        data_rx                = 8'($urandom);
        nack                   = 1'($urandom);
    endtask

    task automatic modelReset();
        m_owner = -1;
        m_gap   = 0;
        m_last  = N - 1;
        m_cnt   = 0;
        m_terr  = '0;
    endtask

    task automatic compareAll();
        logic [31:0] eg;
        logic [31:0] ea;
        logic [31:0] ed;
        logic [31:0] es;
        logic [31:0] ec;
        eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        ea = (m_owner >= 0) ? 32'(req_address[8*m_owner +: 8]) : 32'd0;
        ed = (m_owner >= 0) ? 32'(req_data_tx[8*m_owner +: 8]) : 32'd0;
        es = (m_owner >= 0) ? 32'(req_transfer_start[m_owner]) : 32'd0;
        ec = (m_owner >= 0) ? 32'(req_transfer_continues[m_owner]) : 32'd0;
        checkOutput("grant", 32'(grant), eg);
        checkOutput("address", 32'(address), ea);
        checkOutput("data_tx", 32'(data_tx), ed);
        checkOutput("transfer_start", 32'(transfer_start), es);
        checkOutput("transfer_continues", 32'(transfer_continues), ec);
        checkOutput("req_transfer_ready", 32'(req_transfer_ready), transfer_ready ? eg : 32'd0);
        checkOutput("req_interrupt", 32'(req_interrupt), interrupt ? eg : 32'd0);
        checkOutput("req_transaction_complete", 32'(req_transaction_complete),
                    transaction_complete ? eg : 32'd0);
        checkOutput("rx_data", 32'(rx_data), 32'(data_rx));
        checkOutput("rx_nack", 32'(rx_nack), 32'(nack));
        checkOutput("rx_address_err", 32'(rx_address_err), 32'(address_err));
        checkOutput("timeout_err", 32'(timeout_err), m_terr);
    endtask

    // Advance the model across one clock edge using the inputs held during that cycle.
    task automatic modelStep();
        bit rel;
        bit idle;
        m_terr = '0;
        if (m_owner >= 0) begin
            rel  = transaction_complete || (interrupt && address_err) ||
                   (!req[m_owner] && transfer_ready && !req_transfer_continues[m_owner]);
            idle = transfer_ready && !req_transfer_start[m_owner];
            if (rel) begin
                m_owner = -1;
                m_gap   = 1;
                m_cnt   = 0;
            end else if (TO_EN && idle && (m_cnt + 1 >= LIMIT)) begin
                m_terr  = 32'd1 << m_owner;
                m_owner = -1;
                m_gap   = 1;
                m_cnt   = 0;
            end else begin
                m_cnt = idle ? m_cnt + 1 : 0;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (transfer_ready) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (req[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_cnt   = 0;
                    break;
                end
            end
        end
    endtask

    task automatic stepCycle(input logic [N-1:0] r, input logic tr, input logic tc,
                             input logic intr, input logic aerr,
                             input logic [N-1:0] st, input logic [N-1:0] co);
        applyStimulus(r, tr, tc, intr, aerr, st, co);
        #2;
        compareAll();
        @(posedge clk_in);
        modelStep();
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 2'b11);
        #2;
        checkOutput("reset_grant", 32'(grant), 32'd0);
        checkOutput("reset_address", 32'(address), 32'd0);
        checkOutput("reset_data_tx", 32'(data_tx), 32'd0);
        checkOutput("reset_start", 32'(transfer_start), 32'd0);
        checkOutput("reset_continues", 32'(transfer_continues), 32'd0);
        checkOutput("reset_ready", 32'(req_transfer_ready), 32'd0);
        checkOutput("reset_timeout_err", 32'(timeout_err), 32'd0);
        @(posedge clk_in);
        #1;
        reset = 1'b0;
        modelReset();
    endtask

    initial begin
        reset = 1'b1;
        doReset();

        // First grant goes to client 0 one cycle after the request.
        stepCycle(2'b11, 1, 0, 0, 0, 2'b00, 2'b00);
        checkOutput("first_grant", 32'(grant), 32'h1);
        stepCycle(2'b11, 1, 0, 0, 0, 2'b01, 2'b01);
        stepCycle(2'b11, 0, 0, 0, 0, 2'b00, 2'b01);
        stepCycle(2'b11, 0, 1, 0, 0, 2'b00, 2'b00);
        checkOutput("rel_gap1", 32'(grant), 32'h0);
        stepCycle(2'b11, 1, 0, 0, 0, 2'b00, 2'b00);
        checkOutput("rel_gap2", 32'(grant), 32'h0);
        stepCycle(2'b11, 1, 0, 0, 0, 2'b00, 2'b00);
        checkOutput("rr_second", 32'(grant), 32'h2);

        // Interrupt while client 1 owns, then completion hands back to client 0.
        stepCycle(2'b11, 1, 0, 1, 0, 2'b00, 2'b10);
        stepCycle(2'b11, 1, 1, 0, 0, 2'b00, 2'b00);
        stepCycle(2'b11, 1, 0, 0, 0, 2'b00, 2'b00);
        stepCycle(2'b11, 1, 0, 0, 0, 2'b00, 2'b00);
        checkOutput("rr_back", 32'(grant), 32'h1);

        // Mid-transaction req drop is held until completion.
        stepCycle(2'b00, 1, 0, 0, 0, 2'b00, 2'b01);
        checkOutput("drop_hold1", 32'(grant), 32'h1);
        stepCycle(2'b00, 1, 0, 0, 0, 2'b00, 2'b01);
        checkOutput("drop_hold2", 32'(grant), 32'h1);
        stepCycle(2'b00, 0, 1, 0, 0, 2'b00, 2'b01);
        checkOutput("drop_release", 32'(grant), 32'h0);
        stepCycle(2'b00, 1, 0, 0, 0, 2'b00, 2'b00);
        stepCycle(2'b00, 1, 0, 0, 0, 2'b00, 2'b00);

        // Address error releases on the next cycle.
        stepCycle(2'b10, 1, 0, 0, 0, 2'b00, 2'b10);
        checkOutput("aerr_grant", 32'(grant), 32'h2);
        stepCycle(2'b10, 1, 0, 1, 1, 2'b00, 2'b10);
        checkOutput("aerr_release", 32'(grant), 32'h0);
        stepCycle(2'b00, 1, 0, 0, 0, 2'b00, 2'b00);
        stepCycle(2'b00, 1, 0, 0, 0, 2'b00, 2'b00);

        // Owner sits idle with the bus ready.
        stepCycle(2'b01, 1, 0, 0, 0, 2'b00, 2'b01);
        checkOutput("idle_grant", 32'(grant), 32'h1);
        for (int i = 0; i < LIMIT; i++) stepCycle(2'b01, 1, 0, 0, 0, 2'b00, 2'b01);
        if (TO_EN) begin
            checkOutput("timeout_grant", 32'(grant), 32'h0);
            checkOutput("timeout_pulse", 32'(timeout_err), 32'h1);
        end else begin
            checkOutput("stuck_grant", 32'(grant), 32'h1);
            checkOutput("stuck_no_err", 32'(timeout_err), 32'h0);
        end
        for (int i = 0; i < 3; i++) stepCycle(2'b00, 1, 0, 0, 0, 2'b00, 2'b00);

        // Busy random traffic, then a reset, then long quiet ownerships that can trip the watchdog.
        for (int i = 0; i < 1500; i++)
            stepCycle(randBits(75), chance(75), chance(8), chance(15), chance(25),
                      randBits(30), randBits(50));
        doReset();
        for (int i = 0; i < 1500; i++)
            stepCycle(randBits(95), chance(90), chance(2), chance(5), chance(25),
                      randBits(10), randBits(50));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
